// File: rtl/instr_fetch.sv
// Fetch stage: PC register, combinational memory read captured into a DEPTH-entry prefetch queue.
// 1-cycle fetch latency, 1-bubble redirect; when full and not popping, the PC and i_addr hold.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_bus,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              fetch;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  // A pop frees the slot this same edge, so a full queue keeps fetching while drained.
  assign fetch       = !redirect & ((count < CNT_W'(DEPTH)) | pop);

  assign i_addr   = pc;
  assign instr    = q_instr[rd_ptr];
  assign instr_pc = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      // Flush wins over any push; a coincident pop is simply absorbed by the flush.
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        pc     <= pc + ADDR_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(fetch) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (fetch) begin
      q_instr[wr_ptr] <= i_bus;
      q_pc[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random ready/redirect traffic against a queue model.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_addr;
  logic [15:0] i_bus;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic [15:0] mem [0:65535];
  assign i_bus = mem[i_addr];

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [15:0] mpc;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_bus(i_bus),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC;
  endtask

  // Compare visible outputs with the model, advance the model by one cycle, then cross the edge.
  task automatic step();
    bit   p;
    bit   f;
    ent_t e;
    chk("mdl_addr", i_addr, mpc);
    chk("mdl_vld", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("mdl_instr", instr, mq[0].ins);
      chk("mdl_pc", instr_pc, mq[0].pc);
    end
    p = (mq.size() != 0) && instr_ready;
    f = !redirect && ((mq.size() < DEPTH) || p);
    if (redirect) begin
      mq.delete();
      mpc = redirect_pc;
    end else begin
      if (p) void'(mq.pop_front());
      if (f) begin
        e.ins = mem[mpc];
        e.pc  = mpc;
        mq.push_back(e);
        mpc = mpc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_stream [4];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hdead; mem[1] = 16'hbeef; mem[2] = 16'h1234; mem[3] = 16'h5678;
    mem[16'h0040] = 16'hcafe;
    exp_stream[0] = 16'hdead; exp_stream[1] = 16'hbeef;
    exp_stream[2] = 16'h1234; exp_stream[3] = 16'h5678;

    rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_addr", i_addr, RESET_PC);
    chk("rst_vld", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0);
    chk("rst_ipc", instr_pc, 16'h0);

    // Reset release and streaming
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("strm_vld", instr_valid, 1'b1);
      chk("strm_instr", instr, exp_stream[k]);
      chk("strm_pc", instr_pc, 16'(k));
    end

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #1;
    chk("arst_vld", instr_valid, 1'b0);
    chk("arst_addr", i_addr, RESET_PC);
    chk("arst_instr", instr, 16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Stall until full, then release
    instr_ready = 1'b0;
    step();
    step();
    chk("full_addr", i_addr, 16'd2);
    chk("full_instr", instr, 16'hdead);
    step();
    chk("hold_addr", i_addr, 16'd2);
    chk("hold_instr", instr, 16'hdead);
    instr_ready = 1'b1;
    step();
    chk("rel_instr1", instr, 16'hbeef);
    chk("rel_addr1", i_addr, 16'd3);
    step();
    chk("rel_instr2", instr, 16'h1234);

    // Redirect while streaming
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("redir_addr", i_addr, 16'h0040);
    chk("redir_vld", instr_valid, 1'b0);
    step();
    chk("redir_instr", instr, 16'hcafe);
    chk("redir_pc", instr_pc, 16'h0040);
    chk("redir_vld2", instr_valid, 1'b1);
    step();
    chk("redir_pc2", instr_pc, 16'h0041);

    // Redirect colliding with a pop on a full queue
    instr_ready = 1'b0;
    step();
    step();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    chk("coll_vld", instr_valid, 1'b0);
    step();
    chk("coll_pc", instr_pc, 16'h0100);

    // PC wrap
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_pc0", instr_pc, 16'hFFFF);
    step();
    chk("wrap_pc1", instr_pc, 16'h0000);
    step();
    chk("wrap_pc2", instr_pc, 16'h0001);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom);
      step();
    end
    redirect = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of `memory`'s instruction port. Holds the program counter, drives `i_addr` and captures the combinational `i_bus` word into a small prefetch queue. Presents instructions with their addresses to decode over a valid/ready handshake, and supports PC redirect with queue flush for branches and jumps.

## Interface
- `ADDR_W`, 16: address width; matches memory `i_addr`.
- `DATA_W`, 16: instruction width; matches memory `i_bus`.
- `DEPTH`, 2: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 16'h0000: PC value loaded on reset.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `i_addr` output ADDR_W: fetch address to memory; equals the PC register.
- `i_bus` input DATA_W: instruction word from memory for `i_addr`, valid same cycle (combinational read).
- `instr_valid` output 1: queue head holds a valid instruction.
- `instr` output DATA_W: queue head instruction.
- `instr_pc` output ADDR_W: address that `instr` was fetched from.
- `instr_ready` input 1: decode accepts head this cycle.
- `redirect` input 1: load new PC and flush queue.
- `redirect_pc` input ADDR_W: target PC when `redirect`=1.

## Operation
- State: `pc`, a queue of DEPTH entries each holding {instr, pc}, read/write pointers and `count` (width log2(DEPTH)+1).
- `pop` = `instr_valid & instr_ready`.
- `fetch` = `!redirect & (count < DEPTH | pop)`.
- On `fetch`: push {`i_bus`, `pc`} at the tail, and set `pc` ← `pc`+1, modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000).
- On `pop`: advance the read pointer.
- `count` next = `count` + fetch − pop.
- Redirect has priority over everything:
  - `pc` ← `redirect_pc`; queue flushed (`count` ← 0, pointers reset).
  - No push that cycle.
  - A coincident `pop` is a completed handshake; decode keeps that instruction.
- `instr_valid` = (`count` != 0). `instr` and `instr_pc` come from the head entry and are combinational from registered state. They hold stable while `instr_valid & !instr_ready`.
- No bubbles at steady state: with `instr_ready` held high, one instruction is delivered per cycle.
- Full and not popping: `pc` holds, `i_addr` holds, no push.
- Empty with `instr_ready`=1: no pop; `instr_valid`=0.

## Timing
- Reset (async assert, any time including mid-operation):
  - `pc` = RESET_PC, so `i_addr` = RESET_PC immediately.
  - `count` = 0 and `instr_valid` = 0.
  - `instr` and `instr_pc` read as 0 (queue storage cleared).
- First rising edge after `rst_n` deasserts captures mem[RESET_PC]. `instr_valid`=1 and `instr_pc`=RESET_PC after that edge: 1-cycle fetch latency.
- Redirect asserted in cycle N:
  - Cycle N+1: `i_addr` = `redirect_pc`, `instr_valid` = 0.
  - Cycle N+2: `instr` = mem[`redirect_pc`], `instr_valid` = 1.
  - Redirect penalty is 1 bubble cycle.
- Back-to-back redirects: each one flushes the queue; the last one wins.
- Stall release: head is consumed the same cycle `instr_ready` rises. When full, a fetch occurs that same cycle (pop frees the slot).
- `i_bus` is sampled only at rising edges where `fetch`=1.

## Test plan
- **Reset/stream:** preload mem[0..3] = 16'hdead, 16'hbeef, 16'h1234, 16'h5678; `instr_ready`=1; release `rst_n` → cycles 1–4 give `instr`/`instr_pc` = dead/0, beef/1, 1234/2, 5678/3 with `instr_valid` continuously high.
- **Stall/full:** `instr_ready`=0 from reset release → after 2 edges `count`=2, `i_addr` stuck at 2, `instr`=16'hdead stable. Raise `instr_ready` → dead, beef, 1234 delivered in consecutive cycles.
- **Redirect:** streaming; assert `redirect` with `redirect_pc`=16'h0040 while mem[0x40]=16'hcafe → next cycle `i_addr`=0x40 and `instr_valid`=0; following cycle `instr`=16'hcafe, `instr_pc`=0x40; stale queued words never appear.
- **Redirect+pop collision:** queue full, `instr_ready`=1 and `redirect`=1 in the same cycle → head counted as consumed once, queue empty next cycle, no duplicate.
- **Wrap:** redirect to 16'hFFFF → `instr_pc` sequence FFFF, 0000, 0001.
- **Async reset mid-stream:** drop `rst_n` between edges → `instr_valid`=0 and `i_addr`=RESET_PC before the next edge; restart matches the reset/stream scenario.
